counter_scheduler: RTL and testbench

- Round-robin scheduler that shares one internal W-bit up-counter (enable-gated, clears on reset) between N requesters.
- Each requester asks for a counting job of programmable length.
- The scheduler grants one requester at a time and sequences the counter through 0..target, honouring a global hold.
- It signals completion with a one-cycle done pulse, and it aborts cleanly if the owner withdraws its request.

---
 rtl/counter_scheduler.sv | 155 +++++++++++++++
 tb/tb_counter_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_scheduler.sv
// counter_scheduler
//   Round-robin scheduler that lends one W-bit up-counter to N requesters.
//   A granted requester gets the counter stepped from 0 up to its latched
//   target. Completion is signalled with a one-cycle done pulse. If the
//   owner drops its request before completion, the job is aborted quietly.
//
// Ports
//   i_clock    system clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   i_req      per-requester job request (level)
//   i_len      per-requester target, requester k at [k*W +: W], sampled at grant
//   i_hold     pauses counting of the running job
//   o_grant    one-hot current owner, zero when idle
//   o_busy     high while a job is running
//   o_count    current counter value
//   o_done     one-cycle completion pulse to the finishing owner
//
// state  | meaning
// S_IDLE | no owner; arbitrate any pending request (done pulse may be high)
// S_RUN  | owner in o_grant; counter advancing toward the latched target

module counter_scheduler #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic           i_clock,
  input  logic           i_reset_n,
  input  logic [N-1:0]   i_req,
  input  logic [N*W-1:0] i_len,
  input  logic           i_hold,
  output logic [N-1:0]   o_grant,
  output logic           o_busy,
  output logic [W-1:0]   o_count,
  output logic [N-1:0]   o_done
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_grant, w_grant_nxt;
  logic [N-1:0]  r_done, w_done_nxt;
  logic [W-1:0]  r_count, w_count_nxt;
  logic [W-1:0]  r_target, w_target_nxt;
  logic [PW-1:0] r_ptr, w_ptr_nxt;

  logic [2*N-1:0] w_req_dbl;
  logic [N-1:0]   w_req_rot;
  logic           w_found;
  logic [PW:0]    w_sum;
  logic [PW-1:0]  w_pick;
  logic [PW-1:0]  w_pick_inc;
  logic [W-1:0]   w_len_sel;
  logic           w_owner_req;

  // Rotating the doubled request vector by the pointer puts the highest
  // priority requester at bit 0, so a plain lowest-set-bit search suffices.
  assign w_req_dbl = {i_req, i_req};
  assign w_req_rot = N'(w_req_dbl >> r_ptr);

  always_comb begin
    w_found = 1'b0;
    w_sum   = '0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && w_req_rot[i]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_ptr} + (PW+1)'(i);
      end
    end
    if (w_sum >= (PW+1)'(N)) begin
      w_pick = PW'(w_sum - (PW+1)'(N));
    end else begin
      w_pick = w_sum[PW-1:0];
    end
  end

  assign w_pick_inc = (w_pick == PW'(N-1)) ? '0 : w_pick + PW'(1);

  always_comb begin
    w_len_sel = '0;
    for (int k = 0; k < N; k++) begin
      if (w_pick == PW'(k)) begin
        w_len_sel = i_len[k*W +: W];
      end
    end
  end

  assign w_owner_req = |(i_req & r_grant);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_done   <= '0;
      r_count  <= '0;
      r_target <= '0;
      r_ptr    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_done   <= w_done_nxt;
      r_count  <= w_count_nxt;
      r_target <= w_target_nxt;
      r_ptr    <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_done_nxt   = '0;
    w_count_nxt  = r_count;
    w_target_nxt = r_target;
    w_ptr_nxt    = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt  = S_RUN;
          w_grant_nxt  = N'(1) << w_pick;
          w_target_nxt = w_len_sel;
          w_count_nxt  = '0;
          w_ptr_nxt    = w_pick_inc;
        end
      end
      S_RUN: begin
        if (!w_owner_req) begin
          // abort: pointer keeps its grant-time value
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
          w_count_nxt = '0;
        end else if (i_hold) begin
          w_count_nxt = r_count;
        end else if (r_count != r_target) begin
          w_count_nxt = r_count + W'(1);
        end else begin
          // count stays at target through the done cycle
          w_state_nxt = S_IDLE;
          w_done_nxt  = r_grant;
          w_grant_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  assign o_grant = r_grant;
  assign o_busy  = (r_state == S_RUN);
  assign o_count = r_count;
  assign o_done  = r_done;

endmodule

// File: tb/tb_counter_scheduler.sv
// tb_counter_scheduler
//   Directed scenarios followed by randomized traffic. A job-level reference
//   model predicts grant and done events into a scoreboard queue; a negedge
//   monitor pops and compares whenever the DUT shows a new grant or a done.

module tb_counter_scheduler;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] len;
  logic           hold;
  logic [N-1:0]   o_grant;
  logic           o_busy;
  logic [W-1:0]   o_count;
  logic [N-1:0]   o_done;

  counter_scheduler #(.N(N), .W(W)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .i_req     (req),
    .i_len     (len),
    .i_hold    (hold),
    .o_grant   (o_grant),
    .o_busy    (o_busy),
    .o_count   (o_count),
    .o_done    (o_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int kind;   // 0 = grant, 1 = done
    int who;
    int cyc;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  // job-level reference model
  bit m_busy;
  int m_owner;
  int m_target;
  int m_count;
  int m_ptr;
  int m_done;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic void reset_model();
    m_busy = 0; m_owner = -1; m_target = 0; m_count = 0; m_ptr = 0; m_done = -1;
    sb.delete();
  endfunction

  function automatic void push_ev(input int kind, input int who);
    ev_t e;
    e.kind = kind; e.who = who; e.cyc = cyc;
    sb.push_back(e);
  endfunction

  // One clock edge of the job-level model, using the inputs the DUT saw.
  function automatic void model_step();
    bit picked;
    m_done = -1;
    if (!rst_n) begin
      reset_model();
      return;
    end
    if (!m_busy) begin
      picked = 0;
      for (int s = 0; s < N; s++) begin
        int k;
        k = (m_ptr + s) % N;
        if (!picked && req[k]) begin
          picked   = 1;
          m_busy   = 1;
          m_owner  = k;
          m_target = int'(len[k*W +: W]);
          m_count  = 0;
          m_ptr    = (k + 1) % N;
          push_ev(0, k);
        end
      end
    end else if (!req[m_owner]) begin
      m_busy  = 0;
      m_count = 0;
    end else if (!hold) begin
      if (m_count < m_target) begin
        m_count++;
      end else begin
        m_busy = 0;
        m_done = m_owner;
        push_ev(1, m_owner);
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
  endtask

  task automatic observe(input int kind, input int who);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected actual kind=%0d who=%0d cyc=%0d required=no event", kind, who, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.who != who || e.cyc != cyc) begin
        errors++;
        $display("FAIL sb_event actual kind=%0d who=%0d cyc=%0d required kind=%0d who=%0d cyc=%0d",
                 kind, who, cyc, e.kind, e.who, e.cyc);
      end
    end
  endtask

  logic [N-1:0] prev_grant = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_grant = '0;
    end else begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL sb_missed actual=no event required kind=%0d who=%0d cyc=%0d",
                 sb[0].kind, sb[0].who, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (o_grant != prev_grant && o_grant != '0) observe(0, idx_of(o_grant));
      if (o_done != '0) observe(1, idx_of(o_done));
      prev_grant = o_grant;
      chk("mon_count", int'(o_count), m_count);
      chk("mon_busy", int'(o_busy), int'(m_busy));
      chk("mon_grant_onehot", int'($countones(o_grant) <= 1), 1);
      chk("mon_done_onehot", int'($countones(o_done) <= 1), 1);
      chk("mon_done_grant_overlap", int'(|(o_done & o_grant)), 0);
    end
  end

  task automatic wait_done(output int who, output int at);
    who = -1;
    at  = -1;
    for (int i = 0; i < 40 && who < 0; i++) begin
      tick();
      if (o_done != '0) begin
        who = idx_of(o_done);
        at  = cyc;
      end
    end
    if (who < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_done actual=no done required=done within 40 cycles (cyc %0d)", cyc);
    end
  endtask

  initial begin
    int who, at, c0;
    int rr_exp[5];

    rst_n = 1'b0; req = '0; len = '0; hold = 1'b0;
    reset_model();
    repeat (3) tick();
    chk("rst_grant", int'(o_grant), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_count", int'(o_count), 0);
    chk("rst_done", int'(o_done), 0);
    rst_n = 1'b1;
    tick();

    // single job, len 5
    c0 = cyc; req = 4'b0001; len[0 +: W] = 4'd5;
    tick();
    chk("single_grant", int'(o_grant), 1);
    chk("single_busy", int'(o_busy), 1);
    chk("single_count0", int'(o_count), 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("single_count", int'(o_count), i);
    end
    wait_done(who, at);
    chk("single_done_who", who, 0);
    chk("single_latency", at - c0, 7);
    chk("single_done_grant", int'(o_grant), 0);
    chk("single_done_count", int'(o_count), 5);
    req = '0;
    tick();

    // zero length on requester 1
    c0 = cyc; req = 4'b0010; len[1*W +: W] = 4'd0;
    tick();
    chk("zero_grant", int'(o_grant), 2);
    chk("zero_count", int'(o_count), 0);
    wait_done(who, at);
    chk("zero_done_who", who, 1);
    chk("zero_latency", at - c0, 2);
    chk("zero_done_count", int'(o_count), 0);
    req = '0;
    tick();

    // hold for 4 cycles on requester 2, len changed after grant
    c0 = cyc; req = 4'b0100; len[2*W +: W] = 4'd3;
    tick();
    chk("hold_grant", int'(o_grant), 4);
    len[2*W +: W] = 4'd15;
    tick();
    chk("hold_count1", int'(o_count), 1);
    hold = 1'b1;
    repeat (4) begin
      tick();
      chk("hold_frozen", int'(o_count), 1);
    end
    hold = 1'b0;
    wait_done(who, at);
    chk("hold_done_who", who, 2);
    chk("hold_latency", at - c0, 9);
    chk("hold_latched_target", int'(o_count), 3);
    req = '0;
    tick();

    // abort by requester 3 at count 2, pending requester 2
    req = 4'b1000; len[3*W +: W] = 4'd6;
    tick();
    chk("abort_grant", int'(o_grant), 8);
    tick();
    tick();
    chk("abort_count2", int'(o_count), 2);
    req = 4'b0100; len[2*W +: W] = 4'd1;
    tick();
    chk("abort_grant0", int'(o_grant), 0);
    chk("abort_busy0", int'(o_busy), 0);
    chk("abort_no_done", int'(o_done), 0);
    chk("abort_count0", int'(o_count), 0);
    tick();
    chk("abort_next_grant", int'(o_grant), 4);
    wait_done(who, at);
    chk("abort_next_done_who", who, 2);
    req = '0;
    tick();

    // async reset mid-run at count 3
    req = 4'b0001; len[0 +: W] = 4'd8;
    tick();
    repeat (3) tick();
    chk("areset_pre_count", int'(o_count), 3);
    #2;
    rst_n = 1'b0;
    reset_model();
    #1;
    chk("areset_grant", int'(o_grant), 0);
    chk("areset_busy", int'(o_busy), 0);
    chk("areset_count", int'(o_count), 0);
    req = 4'b1111;
    len = {4'd2, 4'd2, 4'd2, 4'd2};
    tick();
    rst_n = 1'b1;

    // round robin with all requesters active
    rr_exp = '{0, 1, 2, 3, 0};
    tick();
    chk("rr_first_grant", int'(o_grant), 1);
    for (int j = 0; j < 5; j++) begin
      wait_done(who, at);
      chk("rr_order", who, rr_exp[j]);
      if (j == 4) begin
        req = '0;
      end else begin
        if (who >= 0) req[who] = 1'b0;
        tick();
        chk("rr_next_grant", int'(o_grant), 1 << rr_exp[j+1]);
        if (who >= 0) req[who] = 1'b1;
      end
    end
    tick();

    // full-range target
    c0 = cyc; req = 4'b0001; len[0 +: W] = 4'd15;
    wait_done(who, at);
    chk("max_done_who", who, 0);
    chk("max_latency", at - c0, 17);
    chk("max_count", int'(o_count), 15);
    req = '0;
    tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (m_done >= 0) begin
        req[m_done] = 1'b0;
      end else if (m_busy && $urandom_range(0, 29) == 0) begin
        req[m_owner] = 1'b0;
      end
      for (int k = 0; k < N; k++) begin
        if (!req[k] && k != m_done && !(m_busy && k == m_owner) && $urandom_range(0, 3) == 0)
          req[k] = 1'b1;
      end
      for (int k = 0; k < N; k++) begin
        len[k*W +: W] = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      end
      hold = ($urandom_range(0, 3) == 0);
    end

    req = '0;
    hold = 1'b0;
    repeat (40) tick();
    chk("sb_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
